// File: rtl/sorted_mask_pkg.sv
// Shared types and helpers for the sorted-ID window mask block.
// Window bases are always aligned to the mask width.
package sorted_mask_pkg;

  typedef logic [31:0] data_t;

  localparam int DATA_WIDTH       = $bits(data_t);
  localparam int NUM_ELEMENTS_DEF = 8;
  localparam int MASK_WIDTH_DEF   = 16;

  typedef struct packed {
    data_t                     base_id;
    logic [MASK_WIDTH_DEF-1:0] mask;
  } win_mask_t;

  typedef enum logic [1:0] {
    REL_BELOW,
    REL_IN,
    REL_AHEAD
  } rel_e;

  function automatic data_t align_down(input data_t id, input int mw_log);
    data_t hi_mask;
    hi_mask = '1;
    hi_mask = hi_mask << mw_log;
    return id & hi_mask;
  endfunction

endpackage

// File: rtl/seq_window_match.sv
// Per-lane classification of IDs against the current window base (purely combinational).
// Reports below/in/ahead per active lane, the in-window bit index, and the lowest ahead ID.
module seq_window_match
  import sorted_mask_pkg::*;
#(
  parameter int NUM_ELEMENTS = NUM_ELEMENTS_DEF,
  parameter int MASK_WIDTH   = MASK_WIDTH_DEF
) (
  input  logic [NUM_ELEMENTS*DATA_WIDTH-1:0]            lane_data,
  input  logic [NUM_ELEMENTS-1:0]                       lane_act,
  input  logic [DATA_WIDTH-1:0]                         base,
  output logic [NUM_ELEMENTS-1:0]                       below,
  output logic [NUM_ELEMENTS-1:0]                       in_win,
  output logic [NUM_ELEMENTS-1:0]                       ahead,
  output logic [NUM_ELEMENTS*$clog2(MASK_WIDTH)-1:0]    bit_idx,
  output logic [DATA_WIDTH-1:0]                         ahead_id
);

  localparam int MW_LOG = $clog2(MASK_WIDTH);

  data_t rel [NUM_ELEMENTS];
  rel_e  st  [NUM_ELEMENTS];

  // Modulo subtraction lets a window straddle the top of the ID space.
  always_comb begin
    for (int i = 0; i < NUM_ELEMENTS; i++) begin
      rel[i] = lane_data[i*DATA_WIDTH +: DATA_WIDTH] - base;
      if (rel[i][DATA_WIDTH-1]) begin
        st[i] = REL_BELOW;
      end else if (rel[i] < data_t'(MASK_WIDTH)) begin
        st[i] = REL_IN;
      end else begin
        st[i] = REL_AHEAD;
      end
    end
  end

  // Descending scan so the lowest-index ahead lane (the smallest ID) wins.
  always_comb begin
    below    = '0;
    in_win   = '0;
    ahead    = '0;
    bit_idx  = '0;
    ahead_id = '0;
    for (int i = NUM_ELEMENTS - 1; i >= 0; i--) begin
      if (lane_act[i]) begin
        below[i]  = (st[i] == REL_BELOW);
        in_win[i] = (st[i] == REL_IN);
        ahead[i]  = (st[i] == REL_AHEAD);
        bit_idx[i*MW_LOG +: MW_LOG] = rel[i][MW_LOG-1:0];
        if (st[i] == REL_AHEAD) begin
          ahead_id = lane_data[i*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
  end

endmodule

// File: rtl/sorted_seq_window_mask.sv
// Ascending-ID beats to {base_id, mask} windows; registered output, 1 mask/cycle, 1-cycle latency.
// A stalled output freezes all state; in_ready rises only once every kept lane of the beat is placed.
module sorted_seq_window_mask
  import sorted_mask_pkg::*;
#(
  parameter int NUM_ELEMENTS = NUM_ELEMENTS_DEF,
  parameter int MASK_WIDTH   = MASK_WIDTH_DEF,
  parameter int SKIP_EMPTY   = 0
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [DATA_WIDTH-1:0]                cfg_start_id,
  input  logic [NUM_ELEMENTS*DATA_WIDTH-1:0]   in_data,
  input  logic [NUM_ELEMENTS-1:0]              in_keep,
  input  logic                                 in_last,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  output logic [DATA_WIDTH+MASK_WIDTH-1:0]     out_data,
  output logic                                 out_keep,
  output logic                                 out_last,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic                                 err_order
);

  localparam int    MW_LOG  = $clog2(MASK_WIDTH);
  localparam data_t MW_STEP = data_t'(MASK_WIDTH);

  logic                    start_pending_q, start_pending_d;
  data_t                   base_q, base_d;
  logic [MASK_WIDTH-1:0]   acc_q, acc_d;
  logic [NUM_ELEMENTS-1:0] processed_q, processed_d;
  logic                    out_valid_q, out_valid_d;
  logic                    out_last_q, out_last_d;
  logic                    out_keep_q, out_keep_d;
  data_t                   out_base_q, out_base_d;
  logic [MASK_WIDTH-1:0]   out_mask_q, out_mask_d;
  logic                    err_q, err_d;

  logic                    out_slot_free;
  logic                    pending;
  logic                    advance;
  logic                    beat_done;
  logic                    any_ahead;
  logic                    close_win;
  data_t                   eff_base;
  data_t                   next_base;
  data_t                   ahead_id;
  logic [NUM_ELEMENTS-1:0] lane_act;
  logic [NUM_ELEMENTS-1:0] below;
  logic [NUM_ELEMENTS-1:0] in_win;
  logic [NUM_ELEMENTS-1:0] ahead;
  logic [NUM_ELEMENTS-1:0] cur_processed;
  logic [NUM_ELEMENTS*MW_LOG-1:0] bit_idx;
  logic [MASK_WIDTH-1:0]   cur;
  logic [MASK_WIDTH-1:0]   win_mask;

  assign out_slot_free = !out_valid_q || out_ready;

  // A last beat leaving this cycle re-arms the start, so a back-to-back stream picks up cfg_start_id.
  assign pending  = start_pending_q || (out_valid_q && out_last_q && out_ready);
  assign eff_base = pending ? align_down(cfg_start_id, MW_LOG) : base_q;

  // Lanes already placed in an earlier cycle of this beat must not be re-classified against a newer base.
  assign lane_act = in_keep & ~processed_q;

  seq_window_match #(
    .NUM_ELEMENTS (NUM_ELEMENTS),
    .MASK_WIDTH   (MASK_WIDTH)
  ) u_match (
    .lane_data (in_data),
    .lane_act  (lane_act),
    .base      (eff_base),
    .below     (below),
    .in_win    (in_win),
    .ahead     (ahead),
    .bit_idx   (bit_idx),
    .ahead_id  (ahead_id)
  );

  always_comb begin
    cur = '0;
    for (int i = 0; i < NUM_ELEMENTS; i++) begin
      if (in_win[i]) begin
        cur[bit_idx[i*MW_LOG +: MW_LOG]] = 1'b1;
      end
    end
  end

  assign any_ahead     = |ahead;
  assign cur_processed = below | in_win;
  assign beat_done     = ((processed_q | cur_processed) == in_keep);
  assign win_mask      = acc_q | cur;
  assign advance       = in_valid && out_slot_free;
  assign close_win     = advance && (any_ahead || win_mask[MASK_WIDTH-1] || (beat_done && in_last));
  assign in_ready      = in_valid && beat_done && out_slot_free;

  always_comb begin
    if ((SKIP_EMPTY != 0) && any_ahead) begin
      next_base = align_down(ahead_id, MW_LOG);
    end else begin
      next_base = eff_base + MW_STEP;
    end
  end

  always_comb begin
    start_pending_d = start_pending_q;
    base_d          = base_q;
    acc_d           = acc_q;
    processed_d     = processed_q;
    out_valid_d     = out_valid_q;
    out_last_d      = out_last_q;
    out_keep_d      = out_keep_q;
    out_base_d      = out_base_q;
    out_mask_d      = out_mask_q;
    err_d           = err_q;

    if (out_slot_free) begin
      out_valid_d     = 1'b0;
      out_last_d      = 1'b0;
      out_keep_d      = 1'b0;
      start_pending_d = pending;
      if (advance) begin
        start_pending_d = 1'b0;
        base_d          = eff_base;
        err_d           = err_q | (|below);
        processed_d     = beat_done ? '0 : (processed_q | cur_processed);
        if (close_win) begin
          out_valid_d = 1'b1;
          out_keep_d  = 1'b1;
          out_last_d  = beat_done && in_last;
          out_base_d  = eff_base;
          out_mask_d  = win_mask;
          acc_d       = '0;
          base_d      = next_base;
        end else begin
          acc_d = win_mask;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_pending_q <= 1'b1;
      base_q          <= '0;
      acc_q           <= '0;
      processed_q     <= '0;
      out_valid_q     <= 1'b0;
      out_last_q      <= 1'b0;
      out_keep_q      <= 1'b0;
      out_base_q      <= '0;
      out_mask_q      <= '0;
      err_q           <= 1'b0;
    end else begin
      start_pending_q <= start_pending_d;
      base_q          <= base_d;
      acc_q           <= acc_d;
      processed_q     <= processed_d;
      out_valid_q     <= out_valid_d;
      out_last_q      <= out_last_d;
      out_keep_q      <= out_keep_d;
      out_base_q      <= out_base_d;
      out_mask_q      <= out_mask_d;
      err_q           <= err_d;
    end
  end

  assign out_data  = {out_base_q, out_mask_q};
  assign out_keep  = out_keep_q;
  assign out_last  = out_last_q;
  assign out_valid = out_valid_q;
  assign err_order = err_q;

endmodule

// File: tb/tb_sorted_seq_window_mask.sv
// Directed bench: two instances (NE=4, MW=8), index 0 emits gap windows, index 1 skips them.
module tb_sorted_seq_window_mask;

  localparam int NE = 4;
  localparam int MW = 8;
  localparam int DW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n;
  logic [DW-1:0]     cfg_start_id;
  logic [NE*DW-1:0]  in_data   [2];
  logic [NE-1:0]     in_keep   [2];
  logic              in_last   [2];
  logic              in_valid  [2];
  logic              in_ready  [2];
  logic [DW+MW-1:0]  out_data  [2];
  logic              out_keep  [2];
  logic              out_last  [2];
  logic              out_valid [2];
  logic              out_ready [2];
  logic              err_order [2];

  int n_cmp = 0;
  int n_bad = 0;

  logic [DW+MW+1:0] obs0 [$];
  logic [DW+MW+1:0] obs1 [$];

  sorted_seq_window_mask #(.NUM_ELEMENTS(NE), .MASK_WIDTH(MW), .SKIP_EMPTY(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .cfg_start_id(cfg_start_id),
    .in_data(in_data[0]), .in_keep(in_keep[0]), .in_last(in_last[0]),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .out_data(out_data[0]), .out_keep(out_keep[0]), .out_last(out_last[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .err_order(err_order[0])
  );

  sorted_seq_window_mask #(.NUM_ELEMENTS(NE), .MASK_WIDTH(MW), .SKIP_EMPTY(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .cfg_start_id(cfg_start_id),
    .in_data(in_data[1]), .in_keep(in_keep[1]), .in_last(in_last[1]),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .out_data(out_data[1]), .out_keep(out_keep[1]), .out_last(out_last[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .err_order(err_order[1])
  );

  // Record every accepted output beat as {keep, last, base_id, mask}.
  always @(negedge clk) begin
    if (rst_n && out_valid[0] && out_ready[0]) obs0.push_back({out_keep[0], out_last[0], out_data[0]});
    if (rst_n && out_valid[1] && out_ready[1]) obs1.push_back({out_keep[1], out_last[1], out_data[1]});
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [NE*DW-1:0] pk(input logic [31:0] a, input logic [31:0] b,
                                          input logic [31:0] c, input logic [31:0] e);
    return {e, c, b, a};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_out(input int d, input logic [31:0] b, input logic [7:0] m,
                            input logic l, input string tag);
    logic [DW+MW+1:0] got;
    got = 'x;
    if (d == 0 && obs0.size() != 0) got = obs0.pop_front();
    else if (d == 1 && obs1.size() != 0) got = obs1.pop_front();
    chk(tag, 64'(got), 64'({1'b1, l, b, m}));
  endtask

  task automatic expect_empty(input int d, input string tag);
    int n;
    n = (d == 0) ? obs0.size() : obs1.size();
    chk(tag, 64'(n), 64'd0);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_accept(input int d, input string tag);
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready[d] && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_accept"}, 64'(in_ready[d]), 64'd1);
    @(posedge clk);
    #1;
    in_valid[d] = 1'b0;
  endtask

  task automatic send(input int d, input logic [NE*DW-1:0] dat, input logic [NE-1:0] k,
                      input logic l, input string tag);
    in_data[d]  = dat;
    in_keep[d]  = k;
    in_last[d]  = l;
    in_valid[d] = 1'b1;
    wait_accept(d, tag);
  endtask

  initial begin
    rst_n        = 1'b0;
    cfg_start_id = '0;
    for (int d = 0; d < 2; d++) begin
      in_data[d]   = '0;
      in_keep[d]   = '0;
      in_last[d]   = 1'b0;
      in_valid[d]  = 1'b0;
      out_ready[d] = 1'b1;
    end
    repeat (2) @(posedge clk);
    #1;

    // Reset state
    chk("rst_out_valid", 64'(out_valid[0]), 64'd0);
    chk("rst_out_last",  64'(out_last[0]),  64'd0);
    chk("rst_out_keep",  64'(out_keep[0]),  64'd0);
    chk("rst_out_data",  64'(out_data[0]),  64'd0);
    chk("rst_err",       64'(err_order[0]), 64'd0);
    chk("rst_in_ready",  64'(in_ready[0]),  64'd0);
    chk("rst_out_valid1", 64'(out_valid[1]), 64'd0);
    rst_n = 1'b1;
    idle(1);

    // Single beat fully inside window 0
    send(0, pk(1, 3, 5, 6), 4'hF, 1'b1, "t1");
    idle(3);
    expect_out(0, 32'd0, 8'h6A, 1'b1, "t1_beat");
    expect_empty(0, "t1_count");

    // Gap with zero-mask window, in_ready only on the third cycle
    in_data[0]  = pk(2, 19, 0, 0);
    in_keep[0]  = 4'h3;
    in_last[0]  = 1'b1;
    in_valid[0] = 1'b1;
    @(negedge clk);
    chk("t2_rdy_c1", 64'(in_ready[0]), 64'd0);
    @(negedge clk);
    chk("t2_rdy_c2", 64'(in_ready[0]), 64'd0);
    @(negedge clk);
    chk("t2_rdy_c3", 64'(in_ready[0]), 64'd1);
    @(posedge clk);
    #1;
    in_valid[0] = 1'b0;
    idle(3);
    expect_out(0, 32'd0,  8'h04, 1'b0, "t2_w0");
    expect_out(0, 32'd8,  8'h00, 1'b0, "t2_w8");
    expect_out(0, 32'd16, 8'h08, 1'b1, "t2_w16");
    expect_empty(0, "t2_count");

    // Same stimulus, skipping the empty window
    send(1, pk(2, 19, 0, 0), 4'h3, 1'b1, "t3");
    idle(3);
    expect_out(1, 32'd0,  8'h04, 1'b0, "t3_w0");
    expect_out(1, 32'd16, 8'h08, 1'b1, "t3_w16");
    expect_empty(1, "t3_count");

    // Top bit closes the window at once
    send(0, pk(7, 0, 0, 0), 4'h1, 1'b0, "t4a");
    idle(2);
    expect_out(0, 32'd0, 8'h80, 1'b0, "t4_top");
    send(0, pk(8, 9, 0, 0), 4'h3, 1'b1, "t4b");
    idle(3);
    expect_out(0, 32'd8, 8'h03, 1'b1, "t4_next");
    expect_empty(0, "t4_count");

    // Order error: ID 4 below base 8 is dropped
    chk("t6_err_pre", 64'(err_order[0]), 64'd0);
    send(0, pk(7, 0, 0, 0), 4'h1, 1'b0, "t6a");
    send(0, pk(10, 4, 0, 0), 4'h3, 1'b1, "t6b");
    idle(3);
    expect_out(0, 32'd0, 8'h80, 1'b0, "t6_w0");
    expect_out(0, 32'd8, 8'h04, 1'b1, "t6_w8");
    chk("t6_err_set", 64'(err_order[0]), 64'd1);

    // keep=0, last=1 closes an all-zero window
    send(0, pk(0, 0, 0, 0), 4'h0, 1'b1, "t7");
    idle(3);
    expect_out(0, 32'd0, 8'h00, 1'b1, "t7_empty_last");
    chk("t7_err_sticky", 64'(err_order[0]), 64'd1);
    expect_empty(0, "t7_count");

    // Wrap-around through 2^32
    cfg_start_id = 32'hFFFF_FFFB;
    send(0, pk(32'hFFFF_FFFF, 1, 0, 0), 4'h3, 1'b1, "t8");
    idle(3);
    expect_out(0, 32'hFFFF_FFF8, 8'h80, 1'b0, "t8_hi");
    expect_out(0, 32'h0000_0000, 8'h02, 1'b1, "t8_lo");
    send(1, pk(32'hFFFF_FFFF, 1, 0, 0), 4'h3, 1'b1, "t8s");
    idle(3);
    expect_out(1, 32'hFFFF_FFF8, 8'h80, 1'b0, "t8s_hi");
    expect_out(1, 32'h0000_0000, 8'h02, 1'b1, "t8s_lo");
    expect_empty(1, "t8s_count");

    // Large gap with skipping: straight to window 40
    cfg_start_id = 32'd0;
    send(1, pk(2, 40, 0, 0), 4'h3, 1'b1, "t9");
    idle(3);
    expect_out(1, 32'd0,  8'h04, 1'b0, "t9_w0");
    expect_out(1, 32'd40, 8'h01, 1'b1, "t9_w40");
    expect_empty(1, "t9_count");

    // Backpressure: output held for 5 cycles, nothing lost
    out_ready[0] = 1'b0;
    in_data[0]   = pk(2, 19, 0, 0);
    in_keep[0]   = 4'h3;
    in_last[0]   = 1'b1;
    in_valid[0]  = 1'b1;
    @(posedge clk);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("t5_hold_valid", 64'(out_valid[0]), 64'd1);
      chk("t5_hold_data",  64'(out_data[0]),  64'({32'd0, 8'h04}));
      chk("t5_hold_rdy",   64'(in_ready[0]),  64'd0);
    end
    @(posedge clk);
    #1;
    out_ready[0] = 1'b1;
    wait_accept(0, "t5");
    idle(3);
    expect_out(0, 32'd0,  8'h04, 1'b0, "t5_w0");
    expect_out(0, 32'd8,  8'h00, 1'b0, "t5_w8");
    expect_out(0, 32'd16, 8'h08, 1'b1, "t5_w16");
    expect_empty(0, "t5_count");

    // Asynchronous reset mid-stream, then restart at the new start ID
    out_ready[0] = 1'b0;
    send(0, pk(7, 0, 0, 0), 4'h1, 1'b0, "t5r");
    @(negedge clk);
    chk("t5r_held_valid", 64'(out_valid[0]), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5r_async_valid", 64'(out_valid[0]), 64'd0);
    chk("t5r_async_data",  64'(out_data[0]),  64'd0);
    chk("t5r_err_cleared", 64'(err_order[0]), 64'd0);
    #1;
    rst_n        = 1'b1;
    cfg_start_id = 32'h23;
    out_ready[0] = 1'b1;
    @(posedge clk);
    #1;
    send(0, pk(32'h21, 0, 0, 0), 4'h1, 1'b1, "t5n");
    idle(3);
    expect_out(0, 32'h20, 8'h02, 1'b1, "t5n_restart");
    expect_empty(0, "t5n_count");
    chk("end_err1", 64'(err_order[1]), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
